// File: rtl/game_pkg.sv
// game_pkg: shared FSM state encoding and direction codes for the maze-game controller.
//   state_t     : 3-bit controller state (S_IDLE .. S_LOSE)
//   DIR_*       : 2-bit direction codes driven on dir
//   is_opposite : 1 when two directions point exactly against each other
package game_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_WAIT   = 3'd2,
    S_MOVE   = 3'd3,
    S_SETTLE = 3'd4,
    S_CHECK  = 3'd5,
    S_WIN    = 3'd6,
    S_LOSE   = 3'd7
  } state_t;

  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_DOWN  = 2'b01;
  localparam logic [1:0] DIR_LEFT  = 2'b10;
  localparam logic [1:0] DIR_RIGHT = 2'b11;

  // Opposite pairs differ only in the LSB (up/down, left/right).
  function automatic logic is_opposite(input logic [1:0] a, input logic [1:0] b);
    return (a ^ b) == 2'b01;
  endfunction

endpackage

// File: rtl/move_timer.sv
// move_timer: counts game-tick cycles while enabled and flags the last one.
//   clk     in  system clock
//   resetn  in  synchronous active-high reset
//   clear   in  force count to zero
//   enable  in  advance count (wraps to zero after the last cycle)
//   done    out count == TICK_CYCLES-1
module move_timer #(
  parameter int unsigned TICK_CYCLES = 25_000_000,
  parameter int unsigned TICK_W      = 25
) (
  input  logic clk,
  input  logic resetn,
  input  logic clear,
  input  logic enable,
  output logic done
);

  localparam logic [TICK_W-1:0] LAST = TICK_W'(TICK_CYCLES - 1);

  logic [TICK_W-1:0] r_tick;

  assign done = (r_tick == LAST);

  always_ff @(posedge clk) begin
    if (resetn || clear) begin
      r_tick <= '0;
    end else if (enable) begin
      r_tick <= done ? '0 : r_tick + TICK_W'(1);
    end
  end

endmodule

// File: rtl/game_controller.sv
// game_controller: sequences the 8x8 maze datapath - map load, one move per tick in the
// latched direction, win/lose sampling after each move.
//   clk, resetn              clock, synchronous active-high reset
//   start                    start/restart request (idle or terminal states)
//   up, down, left, right    direction keys (synchronised)
//   win, lose                datapath flags, sampled in S_CHECK only
//   ld_maps, move_en         one-cycle datapath strobes
//   dir                      current move direction
//   playing, won, lost       status
//   move_count               moves this game, saturating
module game_controller
  import game_pkg::*;
#(
  parameter int unsigned TICK_CYCLES = 25_000_000,
  parameter int unsigned TICK_W      = 25,
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned MAX_MOVES   = 0
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             up,
  input  logic             down,
  input  logic             left,
  input  logic             right,
  input  logic             win,
  input  logic             lose,
  output logic             ld_maps,
  output logic             move_en,
  output logic [1:0]       dir,
  output logic             playing,
  output logic             won,
  output logic             lost,
  output logic [CNT_W-1:0] move_count
);

  localparam logic [CNT_W-1:0] CNT_SAT   = '1;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MAX_MOVES);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_tick_done;
  logic             w_timer_clear;
  logic             w_timer_en;
  logic             w_req_valid;
  logic [1:0]       w_req_dir;
  logic [1:0]       r_dir;
  logic [CNT_W-1:0] r_move_count;
  logic             r_ld_maps;
  logic             r_move_en;
  logic             r_playing;
  logic             r_won;
  logic             r_lost;

  assign w_timer_clear = (r_state == S_LOAD);
  assign w_timer_en    = (r_state == S_WAIT);

  move_timer #(
    .TICK_CYCLES(TICK_CYCLES),
    .TICK_W     (TICK_W)
  ) u_move_timer (
    .clk   (clk),
    .resetn(resetn),
    .clear (w_timer_clear),
    .enable(w_timer_en),
    .done  (w_tick_done)
  );

  // Highest-priority key wins; reversal filtering happens at the register.
  always_comb begin
    w_req_valid = 1'b1;
    w_req_dir   = r_dir;
    if (up)         w_req_dir = DIR_UP;
    else if (down)  w_req_dir = DIR_DOWN;
    else if (left)  w_req_dir = DIR_LEFT;
    else if (right) w_req_dir = DIR_RIGHT;
    else            w_req_valid = 1'b0;
  end

  // Next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (start) w_state_nxt = S_LOAD;
      S_LOAD:   w_state_nxt = S_WAIT;
      S_WAIT:   if (w_tick_done) w_state_nxt = S_MOVE;
      S_MOVE:   w_state_nxt = S_SETTLE;
      S_SETTLE: w_state_nxt = S_CHECK;
      S_CHECK: begin
        if (lose)                                           w_state_nxt = S_LOSE;
        else if (win)                                       w_state_nxt = S_WIN;
        else if ((MAX_MOVES != 0) && (r_move_count == CNT_LIMIT)) w_state_nxt = S_LOSE;
        else                                                w_state_nxt = S_WAIT;
      end
      S_WIN:    if (start) w_state_nxt = S_LOAD;
      S_LOSE:   if (start) w_state_nxt = S_LOAD;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // State, registered outputs, direction and move counter.
  always_ff @(posedge clk) begin
    if (resetn) begin
      r_state      <= S_IDLE;
      r_ld_maps    <= 1'b0;
      r_move_en    <= 1'b0;
      r_playing    <= 1'b0;
      r_won        <= 1'b0;
      r_lost       <= 1'b0;
      r_dir        <= DIR_RIGHT;
      r_move_count <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_ld_maps <= (w_state_nxt == S_LOAD);
      r_move_en <= (w_state_nxt == S_MOVE);
      r_playing <= (w_state_nxt inside {S_LOAD, S_WAIT, S_MOVE, S_SETTLE, S_CHECK});
      r_won     <= (w_state_nxt == S_WIN);
      r_lost    <= (w_state_nxt == S_LOSE);
      case (r_state)
        S_LOAD: begin
          r_dir        <= DIR_RIGHT;
          r_move_count <= '0;
        end
        S_WAIT: begin
          if (w_req_valid && !is_opposite(w_req_dir, r_dir)) r_dir <= w_req_dir;
        end
        S_MOVE: begin
          if (r_move_count != CNT_SAT) r_move_count <= r_move_count + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign ld_maps    = r_ld_maps;
  assign move_en    = r_move_en;
  assign dir        = r_dir;
  assign playing    = r_playing;
  assign won        = r_won;
  assign lost       = r_lost;
  assign move_count = r_move_count;

endmodule

// File: tb/tb_game_controller.sv
// tb_game_controller: two controllers (no move limit / limit of 3) driven by shared
// stimulus and compared every cycle against a tick-arithmetic game model.
module tb_game_controller;

  localparam int TICK = 4;
  localparam int TW   = 3;
  localparam int CW   = 8;
  localparam int P    = TICK + 3;  // cycles per move once playing

  logic clk = 1'b0;
  logic resetn, start, up, down, left, right, win, lose;
  logic          ld   [2];
  logic          mv   [2];
  logic          pl   [2];
  logic          wn   [2];
  logic          ls   [2];
  logic [1:0]    dr   [2];
  logic [CW-1:0] mc   [2];

  always #5 clk = ~clk;

  game_controller #(.TICK_CYCLES(TICK), .TICK_W(TW), .CNT_W(CW), .MAX_MOVES(0)) u_dut0 (
    .clk(clk), .resetn(resetn), .start(start), .up(up), .down(down), .left(left),
    .right(right), .win(win), .lose(lose), .ld_maps(ld[0]), .move_en(mv[0]), .dir(dr[0]),
    .playing(pl[0]), .won(wn[0]), .lost(ls[0]), .move_count(mc[0]));

  game_controller #(.TICK_CYCLES(TICK), .TICK_W(TW), .CNT_W(CW), .MAX_MOVES(3)) u_dut1 (
    .clk(clk), .resetn(resetn), .start(start), .up(up), .down(down), .left(left),
    .right(right), .win(win), .lose(lose), .ld_maps(ld[1]), .move_en(mv[1]), .dir(dr[1]),
    .playing(pl[1]), .won(wn[1]), .lost(ls[1]), .move_count(mc[1]));

  int n_tests = 0;
  int n_fail  = 0;
  bit checking = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: mode 0 idle, 1 playing, 2 won, 3 lost; t = cycles since the load cycle.
  int m_mode [2] = '{0, 0};
  int m_t    [2] = '{0, 0};
  int m_cnt  [2] = '{0, 0};
  int m_dir  [2] = '{3, 3};
  int m_max  [2] = '{0, 3};

  task automatic model_step(input int i);
    int ph;
    int req;
    if (resetn) begin
      m_mode[i] = 0; m_t[i] = 0; m_cnt[i] = 0; m_dir[i] = 3;
      return;
    end
    if (m_mode[i] != 1) begin
      if (start) begin m_mode[i] = 1; m_t[i] = 0; end
      return;
    end
    if (m_t[i] == 0) begin
      m_cnt[i] = 0; m_dir[i] = 3; m_t[i] = 1;
      return;
    end
    ph = (m_t[i] - 1) % P;
    if (ph < TICK) begin
      req = -1;
      if (up)         req = 0;
      else if (down)  req = 1;
      else if (left)  req = 2;
      else if (right) req = 3;
      // same axis but different direction means a reversal
      if (req >= 0 && !((req / 2) == (m_dir[i] / 2) && req != m_dir[i])) m_dir[i] = req;
    end
    if (ph == TICK && m_cnt[i] < 255) m_cnt[i]++;
    if (ph == TICK + 2) begin
      if (lose)                                           m_mode[i] = 3;
      else if (win)                                       m_mode[i] = 2;
      else if (m_max[i] != 0 && m_cnt[i] == m_max[i])     m_mode[i] = 3;
    end
    m_t[i]++;
  endtask

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) model_step(i);
  end

  // Every-cycle comparison of both DUTs against the model.
  always @(negedge clk) begin
    if (checking) begin
      for (int i = 0; i < 2; i++) begin
        bit p;
        p = (m_mode[i] == 1);
        chk($sformatf("dut%0d.ld_maps", i),    int'(ld[i]), int'(p && m_t[i] == 0));
        chk($sformatf("dut%0d.move_en", i),    int'(mv[i]),
            int'(p && m_t[i] >= 1 && ((m_t[i] - 1) % P) == TICK));
        chk($sformatf("dut%0d.playing", i),    int'(pl[i]), int'(p));
        chk($sformatf("dut%0d.won", i),        int'(wn[i]), int'(m_mode[i] == 2));
        chk($sformatf("dut%0d.lost", i),       int'(ls[i]), int'(m_mode[i] == 3));
        chk($sformatf("dut%0d.dir", i),        int'(dr[i]), m_dir[i]);
        chk($sformatf("dut%0d.move_count", i), int'(mc[i]), m_cnt[i]);
      end
    end
  end

  task automatic wait_move0(input string nm);
    int k = 0;
    do begin @(negedge clk); k++; end while (!mv[0] && k < 30);
    if (!mv[0]) chk({nm, "_timeout"}, 0, 1);
  endtask

  initial begin
    int k, pulses, prev, first;
    resetn = 1'b1; start = 1'b0; up = 1'b0; down = 1'b0; left = 1'b0; right = 1'b0;
    win = 1'b0; lose = 1'b0;
    repeat (2) @(negedge clk);
    checking = 1'b1;
    // reset state
    chk("rst_dir", int'(dr[0]), 3);
    chk("rst_cnt", int'(mc[0]), 0);
    chk("rst_playing", int'(pl[0]), 0);
    chk("rst_ld", int'(ld[0]), 0);
    resetn = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_ld0", int'(ld[0]), 1);
    chk("start_ld1", int'(ld[1]), 1);

    // first-move latency on dut0, move-limit behaviour on dut1
    k = 0; pulses = 0; prev = -1; first = -1;
    while (!ls[1] && k < 100) begin
      @(negedge clk); k++;
      if (mv[0] && first < 0) begin
        first = k;
        chk("first_move_dir", int'(dr[0]), 3);
        chk("first_move_cnt", int'(mc[0]), 0);
        chk("second_ld", int'(ld[0]), 0);
      end
      if (mv[1]) begin
        pulses++;
        if (prev >= 0) chk("move_period", k - prev, 7);
        prev = k;
      end
    end
    chk("load_to_move", first, 5);
    chk("limit_pulses", pulses, 3);
    chk("limit_lost", int'(ls[1]), 1);
    chk("limit_cnt", int'(mc[1]), 3);

    // win and lose together -> lose
    win = 1'b1; lose = 1'b1;
    k = 0;
    do begin @(negedge clk); k++; end while (!ls[0] && k < 20);
    chk("both_lost", int'(ls[0]), 1);
    chk("both_won", int'(wn[0]), 0);
    win = 1'b0; lose = 1'b0;
    pulses = 0;
    repeat (10) begin @(negedge clk); if (mv[0]) pulses++; end
    chk("no_move_after_lose", pulses, 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("restart_ld", int'(ld[0]), 1);
    @(negedge clk);
    chk("restart_cnt", int'(mc[0]), 0);

    // turn up, then reversal attempt
    up = 1'b1;
    wait_move0("up");
    chk("up_dir", int'(dr[0]), 0);
    up = 1'b0; down = 1'b1;
    wait_move0("down");
    chk("reverse_dir", int'(dr[0]), 0);
    // reset during S_MOVE
    resetn = 1'b1; down = 1'b0;
    @(negedge clk);
    resetn = 1'b0;
    chk("midrst_move", int'(mv[0]), 0);
    chk("midrst_play", int'(pl[0]), 0);
    chk("midrst_cnt", int'(mc[0]), 0);
    chk("midrst_dir", int'(dr[0]), 3);

    // priority up over left, then dir holds with no keys
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    up = 1'b1; left = 1'b1;
    wait_move0("uplft");
    chk("uplft_dir", int'(dr[0]), 0);
    up = 1'b0; left = 1'b0;
    for (int j = 0; j < 3; j++) begin
      wait_move0("hold");
      chk("hold_dir", int'(dr[0]), 0);
    end

    // long game: counter saturates
    repeat (270 * P) @(negedge clk);
    chk("sat_cnt", int'(mc[0]), 255);
    chk("sat_playing", int'(pl[0]), 1);

    // randomized play
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      resetn = ($urandom_range(0, 199) == 0);
      start  = ($urandom_range(0, 7) == 0);
      up     = ($urandom_range(0, 3) == 0);
      down   = ($urandom_range(0, 3) == 0);
      left   = ($urandom_range(0, 3) == 0);
      right  = ($urandom_range(0, 3) == 0);
      win    = ($urandom_range(0, 15) == 0);
      lose   = ($urandom_range(0, 15) == 0);
    end
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
